// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage.
package wb_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [1:0] RES_ALU  = 2'b00;
   localparam logic [1:0] RES_LOAD = 2'b01;
   localparam logic [1:0] RES_PC4  = 2'b10;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_WAIT_LD = 1'b1
   } wb_state_e;

endpackage

// File: rtl/wb_if.sv
// MEM-to-WB retire handshake plus the load-response channel.
interface wb_if #(
   parameter int XLEN = 32
);
   logic            mem_valid;
   logic            mem_ready;
   logic            mem_reg_write;
   logic [4:0]      mem_rd;
   logic [1:0]      mem_result_src;
   logic [XLEN-1:0] mem_alu_result;
   logic [XLEN-1:0] mem_pc_plus4;
   logic            ld_rvalid;
   logic [XLEN-1:0] ld_rdata;

   modport master (
      output mem_valid, mem_reg_write, mem_rd, mem_result_src,
             mem_alu_result, mem_pc_plus4, ld_rvalid, ld_rdata,
      input  mem_ready
   );

   modport slave (
      input  mem_valid, mem_reg_write, mem_rd, mem_result_src,
             mem_alu_result, mem_pc_plus4, ld_rvalid, ld_rdata,
      output mem_ready
   );
endinterface

// File: rtl/wb_bypass.sv
// Write-before-read bypass compare for one decode read port.
module wb_bypass
   import wb_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            rf_we,
   input  logic [4:0]      rf_addr,
   input  logic [XLEN-1:0] rf_wdata,
   input  logic [4:0]      dec_a,
   output logic            byp_hit,
   output logic [XLEN-1:0] byp_data
);

   // Hit when the write landing this edge targets the register being read.
   always_comb begin
      byp_hit  = rf_we && (rf_addr == dec_a) && (dec_a != 5'd0);
      byp_data = rf_wdata;
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: result select, registered RF write port, load wait,
// decode bypass, load-error flag and retired-instruction counter.
//
// state      | meaning
// -----------+-------------------------------------------
// ST_IDLE    | no load outstanding, MEM may retire
// ST_WAIT_LD | load accepted, waiting for ld_rvalid
module wb_stage
   import wb_pkg::*;
#(
   parameter int XLEN       = XLEN_DEF,
   parameter int LD_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   wb_if.slave              mem_if,
   output logic             rf_we,
   output logic [4:0]       rf_addr,
   output logic [XLEN-1:0]  rf_wdata,
   input  logic [4:0]       dec_a1,
   input  logic [4:0]       dec_a2,
   output logic             byp_hit1,
   output logic             byp_hit2,
   output logic [XLEN-1:0]  byp_data1,
   output logic [XLEN-1:0]  byp_data2,
   output logic             ld_err,
   output logic [CNT_W-1:0] retired_cnt
);

   localparam int WAIT_W = (LD_TIMEOUT > 2) ? $clog2(LD_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(LD_TIMEOUT - 1);

   wb_state_e         state_q, state_d;
   logic              rf_we_q, rf_we_d;
   logic [4:0]        rf_addr_q, rf_addr_d;
   logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  retired_cnt_q, retired_cnt_d;
   logic              ld_err_q, ld_err_d;
   logic [4:0]        ld_rd_q, ld_rd_d;
   logic              ld_we_q, ld_we_d;

   logic mem_ready;
   logic accept;
   logic is_load;
   logic timeout;

   assign mem_ready        = !rst && (state_q == ST_IDLE);
   assign mem_if.mem_ready = mem_ready;
   assign accept           = mem_if.mem_valid && mem_ready;
   assign is_load          = (mem_if.mem_result_src == RES_LOAD);
   assign timeout          = (wait_cnt_q == WAIT_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state: enter WAIT_LD on a load accept, leave on data or timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (accept && is_load) state_d = ST_WAIT_LD;
         ST_WAIT_LD: if (mem_if.ld_rvalid || timeout) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Datapath next values; rf_addr/rf_wdata only move when a write happens.
   always_comb begin
      rf_we_d       = 1'b0;
      rf_addr_d     = rf_addr_q;
      rf_wdata_d    = rf_wdata_q;
      wait_cnt_d    = wait_cnt_q;
      retired_cnt_d = retired_cnt_q;
      ld_err_d      = ld_err_q;
      ld_rd_d       = ld_rd_q;
      ld_we_d       = ld_we_q;
      case (state_q)
         ST_IDLE: begin
            if (mem_if.ld_rvalid) ld_err_d = 1'b1;
            if (accept) begin
               if (is_load) begin
                  ld_rd_d    = mem_if.mem_rd;
                  ld_we_d    = mem_if.mem_reg_write && (mem_if.mem_rd != 5'd0);
                  wait_cnt_d = '0;
               end else begin
                  retired_cnt_d = retired_cnt_q + CNT_W'(1);
                  if (mem_if.mem_reg_write && (mem_if.mem_rd != 5'd0)) begin
                     rf_we_d    = 1'b1;
                     rf_addr_d  = mem_if.mem_rd;
                     rf_wdata_d = (mem_if.mem_result_src == RES_PC4) ?
                                  mem_if.mem_pc_plus4 : mem_if.mem_alu_result;
                  end
               end
            end
         end
         ST_WAIT_LD: begin
            if (mem_if.ld_rvalid) begin
               retired_cnt_d = retired_cnt_q + CNT_W'(1);
               if (ld_we_q) begin
                  rf_we_d    = 1'b1;
                  rf_addr_d  = ld_rd_q;
                  rf_wdata_d = mem_if.ld_rdata;
               end
            end else if (timeout) begin
               ld_err_d      = 1'b1;
               wait_cnt_d    = '0;
               retired_cnt_d = retired_cnt_q + CNT_W'(1);
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we_q       <= 1'b0;
         rf_addr_q     <= 5'd0;
         rf_wdata_q    <= '0;
         wait_cnt_q    <= '0;
         retired_cnt_q <= '0;
         ld_err_q      <= 1'b0;
         ld_rd_q       <= 5'd0;
         ld_we_q       <= 1'b0;
      end else begin
         rf_we_q       <= rf_we_d;
         rf_addr_q     <= rf_addr_d;
         rf_wdata_q    <= rf_wdata_d;
         wait_cnt_q    <= wait_cnt_d;
         retired_cnt_q <= retired_cnt_d;
         ld_err_q      <= ld_err_d;
         ld_rd_q       <= ld_rd_d;
         ld_we_q       <= ld_we_d;
      end
   end

   assign rf_we       = rf_we_q;
   assign rf_addr     = rf_addr_q;
   assign rf_wdata    = rf_wdata_q;
   assign ld_err      = ld_err_q;
   assign retired_cnt = retired_cnt_q;

   wb_bypass #(.XLEN(XLEN)) u_byp1 (
      .rf_we    (rf_we_q),
      .rf_addr  (rf_addr_q),
      .rf_wdata (rf_wdata_q),
      .dec_a    (dec_a1),
      .byp_hit  (byp_hit1),
      .byp_data (byp_data1)
   );

   wb_bypass #(.XLEN(XLEN)) u_byp2 (
      .rf_we    (rf_we_q),
      .rf_addr  (rf_addr_q),
      .rf_wdata (rf_wdata_q),
      .dec_a    (dec_a2),
      .byp_hit  (byp_hit2),
      .byp_data (byp_data2)
   );

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the pipelined RISC-V core.
- Accepts retiring instructions from the MEM stage, selects the result (ALU, load data, PC+4) and drives the register-file write port (WE3/A3/WD3) with registered outputs.
- Waits on a variable-latency load-response handshake and stalls MEM meanwhile.
- Provides decode-stage write-before-read bypass, a load-timeout error flag and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath width.
- LD_TIMEOUT, 64, maximum cycles spent in WAIT_LD before abort; must be ≥ 2.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- mem_valid  in  1  MEM stage presents an instruction.
- mem_ready  out  1  stage can accept this cycle.
- mem_reg_write  in  1  instruction writes rd.
- mem_rd  in  5  destination register.
- mem_result_src  in  2  00 ALU, 01 LOAD, 10 PC+4, 11 reserved.
- mem_alu_result  in  XLEN  ALU result.
- mem_pc_plus4  in  XLEN  link value.
- ld_rvalid  in  1  load data valid (single-cycle pulse).
- ld_rdata  in  XLEN  load data.
- rf_we  out  1  register-file write enable (to WE3).
- rf_addr  out  5  write address (to A3).
- rf_wdata  out  XLEN  write data (to WD3).
- dec_a1, dec_a2  in  5 each  decode read addresses.
- byp_hit1, byp_hit2  out  1 each  bypass valid for a1/a2.
- byp_data1, byp_data2  out  XLEN each  bypass data.
- ld_err  out  1  sticky load error.
- retired_cnt  out  CNT_W  instructions completed.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; rf_we=0, rf_addr=0, rf_wdata=0.
  - wait_cnt=0, retired_cnt=0, ld_err=0.
  - mem_ready=0 while rst=1.
- States:
  - IDLE: no load outstanding.
  - WAIT_LD: load accepted, data pending.
- mem_ready = !rst && state==IDLE (combinational).
- Accept occurs at a posedge with mem_valid && mem_ready.
- rf_we/rf_addr/rf_wdata are registered and default each cycle to rf_we=0. rf_addr/rf_wdata hold their last values when rf_we=0.
- Accept, non-load (src 00/10/11):
  - Next cycle: rf_we = mem_reg_write && mem_rd!=0; rf_addr = mem_rd.
  - rf_wdata = pc_plus4 for src 10, otherwise alu_result.
  - retired_cnt += 1. Latency 1 cycle.
- Accept, load (src 01):
  - Capture rd (a write is suppressed if rd==0 or mem_reg_write==0).
  - wait_cnt=0; state goes to WAIT_LD; no write.
- WAIT_LD with ld_rvalid=1:
  - Next cycle: rf_we = pending-write flag; rf_addr = captured rd; rf_wdata = ld_rdata.
  - retired_cnt += 1; state goes to IDLE.
  - mem_ready stays 0 during that edge, giving one bubble, so two writes can never collide.
- WAIT_LD without ld_rvalid: wait_cnt += 1.
  - When wait_cnt==LD_TIMEOUT-1: ld_err=1, state goes to IDLE, no write, retired_cnt += 1.
- ld_rvalid while IDLE is spurious: set ld_err=1, data ignored, no write. This also applies in the same cycle as an accept; the accept proceeds normally.
- ld_err is sticky and cleared only by rst.
- retired_cnt wraps modulo 2^CNT_W.
- Bypass (combinational): byp_hitN = rf_we && rf_addr==dec_aN && dec_aN!=0; byp_dataN = rf_wdata. This covers the register file's same-edge write/read.
- rf_addr=0 is never written (x0 protection).
- Reset during WAIT_LD: the outstanding load is abandoned. A later ld_rvalid is treated as spurious (ld_err).

Decomposition:
- Package wb_pkg:
  - RES_ALU=2'b00, RES_LOAD=2'b01, RES_PC4=2'b10.
  - State encoding IDLE/WAIT_LD.
  - XLEN default.
- Sub-module wb_bypass: pure combinational compare for one read port, instantiated twice.

Test Plan:
- ALU op: mem_valid, src=00, rd=5, alu=0x00000006, reg_write=1 → next cycle rf_we=1, rf_addr=5, rf_wdata=0x6, retired_cnt=1; dec_a1=5 gives byp_hit1=1, byp_data1=0x6.
- JAL link: src=10, rd=1, pc_plus4=0x00000040 → rf_wdata=0x40 at rf_addr=1; write to rd=0 with src=00 → rf_we stays 0, retired_cnt still increments.
- Load latency 3: accept load rd=6, ld_rvalid with 0x0000000A three cycles later → mem_ready=0 from the accept edge until the write edge; rf_we=1, rf_addr=6, rf_wdata=0xA exactly one cycle after rvalid; no write earlier.
- Timeout, LD_TIMEOUT=4: accept load, no rvalid → after 4 cycles in WAIT_LD, ld_err=1, state IDLE, no rf write; ld_err persists until rst.
- Spurious rvalid in IDLE → ld_err=1, rf_we=0. Reset asserted mid-WAIT_LD → all outputs zero next cycle, mem_ready=1 after rst deasserts.
- Back-to-back ALU ops every cycle (rd 1..8) → one write per cycle in order, mem_ready constantly 1, retired_cnt=8.
